// File: rtl/ps2_scan_rx_if.sv
// Key-event bus from the PS/2 scan-code receiver to its consumer.
// The receiver drives through the master modport; the consumer reads through slave.
interface ps2_scan_rx_if;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output key_code,
    output key_ext,
    output key_release,
    output key_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input key_code,
    input key_ext,
    input key_release,
    input key_valid,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver.
// Synchronises and deglitches the keyboard clock/data pins, assembles 11-bit
// device frames (start, 8 data LSB first, odd parity, stop), folds the E0
// (extended) and F0 (break) prefixes into flags and emits one key event per
// make/break code on the key-event interface.
// Optional feature: define PS2_RX_TIMEOUT_EN to abort a frame that stalls for
// TIMEOUT_CYCLES clk cycles between filtered clock falls.
module ps2_scan_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  ps2_scan_rx_if.master key_if
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
    odd_parity_ok = ^{data_byte, par_bit};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_synced_s;
  logic                   data_synced_s;

  logic [FILTER_LEN-1:0]  filt_sh_q;
  logic                   filt_clk_q;
  logic                   filt_clk_d;
  logic                   fall_s;
  logic                   timeout_s;

  state_e                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   parity_q;
  logic                   ext_flag_q;
  logic                   rel_flag_q;
  logic [7:0]             key_code_q;
  logic                   key_ext_q;
  logic                   key_rel_q;
  logic                   key_valid_q;
  logic                   frame_err_q;
  logic                   busy_q;

  // Bring both raw pins into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      data_sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  assign clk_synced_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_synced_s = data_sync_q[SYNC_STAGES-1];

  // History of synced clock samples plus the filtered clock level.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_sh_q  <= {FILTER_LEN{1'b1}};
      filt_clk_q <= 1'b1;
    end else begin
      filt_sh_q  <= {filt_sh_q[FILTER_LEN-2:0], clk_synced_s};
      filt_clk_q <= filt_clk_d;
    end
  end

  // Filtered clock only moves once the whole history agrees; otherwise it holds.
  always_comb begin
    filt_clk_d = filt_clk_q;
    if (filt_sh_q == {FILTER_LEN{1'b0}}) begin
      filt_clk_d = 1'b0;
    end else if (filt_sh_q == {FILTER_LEN{1'b1}}) begin
      filt_clk_d = 1'b1;
    end else begin
      filt_clk_d = filt_clk_q;
    end
  end

  // A fall is the cycle in which the filtered clock is about to drop; data is sampled then.
  assign fall_s = filt_clk_q & ~filt_clk_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  // Idle-time counter: restarts on every fall and while idle, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= TO_W'(0);
    end else if (fall_s || (state_q == ST_IDLE)) begin
      to_cnt_q <= TO_W'(0);
    end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= to_cnt_q;
    end
  end

  assign timeout_s = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
  // Without the watchdog a stalled frame simply waits for the next fall.
  assign timeout_s = 1'b0;
`endif

  // Frame FSM with registered key-event outputs; a fall always takes priority over timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      ext_flag_q  <= 1'b0;
      rel_flag_q  <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_s) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_synced_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= 3'd0;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_q   <= {data_synced_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_PARITY: begin
            parity_q <= data_synced_s;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (odd_parity_ok(shift_q, parity_q) && data_synced_s) begin
              if (shift_q == 8'hE0) begin
                ext_flag_q <= 1'b1;
              end else if (shift_q == 8'hF0) begin
                rel_flag_q <= 1'b1;
              end else begin
                key_code_q  <= shift_q;
                key_ext_q   <= ext_flag_q;
                key_rel_q   <= rel_flag_q;
                key_valid_q <= 1'b1;
                ext_flag_q  <= 1'b0;
                rel_flag_q  <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_flag_q  <= 1'b0;
              rel_flag_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (timeout_s) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        frame_err_q <= 1'b1;
        ext_flag_q  <= 1'b0;
        rel_flag_q  <= 1'b0;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign key_if.key_code    = key_code_q;
  assign key_if.key_ext     = key_ext_q;
  assign key_if.key_release = key_rel_q;
  assign key_if.key_valid   = key_valid_q;
  assign key_if.frame_err   = frame_err_q;
  assign key_if.busy        = busy_q;

endmodule
